arith_arbiter: RTL

ARITH_ARBITER -- requirements
Module: arith_arbiter

---
 rtl/arith_arbiter.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/arith_arbiter.sv
// arith_arbiter: two requesters share one sequential signed ALU through a
// round-robin arbiter. ADD/SUB finish after one EXEC cycle; MUL (shift-add)
// and DIV (restoring) iterate N cycles on operand magnitudes, then fix signs.
// Optional feature macro ARITH_DIVZERO_ERR_EN: adds the err port and lets a
// divide by zero finish early with result 0 and err=1.
module arith_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [1:0]     op0,
  input  logic [1:0]     op1,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           busy,
  output logic           done,
  output logic           done_id,
  output logic [2*N-1:0] result
`ifdef ARITH_DIVZERO_ERR_EN
  ,
  output logic           err
`endif
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [1:0]    OP_ADD   = 2'b00;
  localparam logic [1:0]    OP_SUB   = 2'b01;
  localparam logic [1:0]    OP_MUL   = 2'b10;
  localparam logic [1:0]    OP_DIV   = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10} state_e;

  // Magnitude of a two's-complement value; -2^(N-1) maps to 2^(N-1) unsigned.
  function automatic logic [N-1:0] mag_f(input logic [N-1:0] v);
    return v[N-1] ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [N-1:0] neg_if_f(input logic [N-1:0] v, input logic neg);
    return neg ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*N-1:0] neg2_if_f(input logic [2*N-1:0] v, input logic neg);
    return neg ? (~v + {{(2*N-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           gnt_q, gnt_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   m_q, m_d;        // multiplicand or divisor magnitude
  logic [N:0]     x_q, x_d;        // product high half or partial remainder
  logic [N-1:0]   y_q, y_d;        // multiplier / product low half, or dividend / quotient
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d, done_id_q, done_id_d;
  logic [2*N-1:0] result_q, result_d;
`ifdef ARITH_DIVZERO_ERR_EN
  logic           err_q, err_d;
`endif

  logic           gnt_s;
  logic [1:0]     op_s;
  logic [N-1:0]   a_s, b_s;
  logic [N:0]     mul_sum_s, mul_x_s, div_sh_s, div_x_s;
  logic [N-1:0]   mul_y_s, div_y_s, quo_s, rem_s;
  logic [2*N-1:0] add_s, sub_s, mul_fin_s;
  logic           dz_s, dz_skip_s, fin_s;
  logic [2*N-1:0] fin_res_s;

  // Round-robin pick: the pointer only matters when both requesters ask.
  always_comb begin
    if (req0 && req1) begin
      gnt_s = ptr_q;
    end else begin
      gnt_s = req1;
    end
    if (gnt_s) begin
      op_s = op1;
      a_s  = a1;
      b_s  = b1;
    end else begin
      op_s = op0;
      a_s  = a0;
      b_s  = b0;
    end
  end

  // One shift-add / restoring-divide iteration plus the sign-corrected finals.
  always_comb begin
    mul_sum_s = x_q + (y_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
    mul_x_s   = {1'b0, mul_sum_s[N:1]};
    mul_y_s   = {mul_sum_s[0], y_q[N-1:1]};
    div_sh_s  = {x_q[N-1:0], y_q[N-1]};
    if (div_sh_s >= {1'b0, m_q}) begin
      div_x_s = div_sh_s - {1'b0, m_q};
      div_y_s = {y_q[N-2:0], 1'b1};
    end else begin
      div_x_s = div_sh_s;
      div_y_s = {y_q[N-2:0], 1'b0};
    end
    dz_s      = (b_q == {N{1'b0}});
    add_s     = {{N{a_q[N-1]}}, a_q} + {{N{b_q[N-1]}}, b_q};
    sub_s     = {{N{a_q[N-1]}}, a_q} - {{N{b_q[N-1]}}, b_q};
    mul_fin_s = neg2_if_f({mul_x_s[N-1:0], mul_y_s}, a_q[N-1] ^ b_q[N-1]);
    quo_s     = dz_s ? {N{1'b1}} : neg_if_f(div_y_s, a_q[N-1] ^ b_q[N-1]);
    rem_s     = neg_if_f(div_x_s[N-1:0], a_q[N-1]);
`ifdef ARITH_DIVZERO_ERR_EN
    dz_skip_s = dz_s;
`else
    dz_skip_s = 1'b0;
`endif
  end

  // Next-state and datapath update for IDLE/EXEC/DONE.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    fin_s     = 1'b0;
    fin_res_s = result_q;
`ifdef ARITH_DIVZERO_ERR_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = EXEC;
          busy_d  = 1'b1;
          gnt_d   = gnt_s;
          op_d    = op_s;
          a_d     = a_s;
          b_d     = b_s;
          cnt_d   = {CW{1'b0}};
          x_d     = {(N+1){1'b0}};
          if (op_s == OP_DIV) begin
            m_d = mag_f(b_s);
            y_d = mag_f(a_s);
          end else begin
            m_d = mag_f(a_s);
            y_d = mag_f(b_s);
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            fin_s     = 1'b1;
            fin_res_s = add_s;
          end
          OP_SUB: begin
            fin_s     = 1'b1;
            fin_res_s = sub_s;
          end
          OP_MUL: begin
            x_d       = mul_x_s;
            y_d       = mul_y_s;
            cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            fin_s     = (cnt_q == CNT_LAST);
            fin_res_s = mul_fin_s;
          end
          OP_DIV: begin
            if (dz_skip_s) begin
              fin_s     = 1'b1;
              fin_res_s = {(2*N){1'b0}};
            end else begin
              x_d       = div_x_s;
              y_d       = div_y_s;
              cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
              fin_s     = (cnt_q == CNT_LAST);
              fin_res_s = {rem_s, quo_s};
            end
          end
          default: begin
            fin_s     = 1'b1;
            fin_res_s = {(2*N){1'b0}};
          end
        endcase
        if (fin_s) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = gnt_q;
          result_d  = fin_res_s;
`ifdef ARITH_DIVZERO_ERR_EN
          err_d     = dz_skip_s && (op_q == OP_DIV);
`endif
        end else begin
          state_d = EXEC;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = ~gnt_q;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      op_q      <= 2'b00;
      a_q       <= {N{1'b0}};
      b_q       <= {N{1'b0}};
      m_q       <= {N{1'b0}};
      x_q       <= {(N+1){1'b0}};
      y_q       <= {N{1'b0}};
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= {(2*N){1'b0}};
`ifdef ARITH_DIVZERO_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
`ifdef ARITH_DIVZERO_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
`ifdef ARITH_DIVZERO_ERR_EN
  assign err     = err_q;
`endif

endmodule
